// File: rtl/div_result_bcd.sv
// div_result_bcd: sequential binary-to-BCD converter for the divider result.
// Quotient and remainder are converted in parallel by shift-add-3, one bit
// per clock, and presented as registered BCD digits with sign/error flags.
// Optional build macro: DIV_BCD_LEADING_BLANK_EN (blank leading zero digits).
module div_result_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      quotient,
  input  logic [WIDTH-1:0]      remainder,
  input  logic                  negative,
  input  logic                  error,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_q,
  output logic [4*DIGITS-1:0]   bcd_r,
  output logic                  neg_out,
  output logic                  err_out
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [BW-1:0] BLANK = {BW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_bin_q;
  logic [WIDTH-1:0] r_bin_r;
  logic [BW-1:0]   r_acc_q;
  logic [BW-1:0]   r_acc_r;
  logic            r_neg;
  logic            r_err;
  logic            r_done;
  logic [BW-1:0]   r_bcd_q;
  logic [BW-1:0]   r_bcd_r;
  logic            r_neg_out;
  logic            r_err_out;

  logic [BW-1:0]   w_adj_q;
  logic [BW-1:0]   w_adj_r;
  logic [BW-1:0]   w_fin_q;
  logic [BW-1:0]   w_fin_r;

  // Add 3 to every digit >= 5 so the following left shift carries correctly.
  function automatic logic [BW-1:0] f_add3(input logic [BW-1:0] a);
    logic [BW-1:0] v;
    v = a;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) v[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return v;
  endfunction

`ifdef DIV_BCD_LEADING_BLANK_EN
  // Replace leading zero digits with the blank code; digit 0 always shows.
  function automatic logic [BW-1:0] f_blank(input logic [BW-1:0] a);
    logic [BW-1:0] v;
    logic          lead;
    v    = a;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && (v[4*i +: 4] == 4'd0)) v[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return v;
  endfunction

  assign w_fin_q = f_blank(r_acc_q);
  assign w_fin_r = f_blank(r_acc_r);
`else
  assign w_fin_q = r_acc_q;
  assign w_fin_r = r_acc_r;
`endif

  assign w_adj_q = f_add3(r_acc_q);
  assign w_adj_r = f_add3(r_acc_r);

  // Conversion FSM with registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bin_q   <= '0;
      r_bin_r   <= '0;
      r_acc_q   <= '0;
      r_acc_r   <= '0;
      r_neg     <= 1'b0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_bcd_q   <= '0;
      r_bcd_r   <= '0;
      r_neg_out <= 1'b0;
      r_err_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && error) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (start) begin
            r_err   <= 1'b0;
            r_bin_q <= quotient;
            r_bin_r <= remainder;
            r_neg   <= negative;
            r_acc_q <= '0;
            r_acc_r <= '0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_acc_q <= {w_adj_q[BW-2:0], r_bin_q[WIDTH-1]};
          r_acc_r <= {w_adj_r[BW-2:0], r_bin_r[WIDTH-1]};
          r_bin_q <= r_bin_q << 1;
          r_bin_r <= r_bin_r << 1;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) r_state <= S_DONE;
        end
        S_DONE: begin
          r_done <= 1'b1;
          if (r_err) begin
            r_bcd_q   <= BLANK;
            r_bcd_r   <= BLANK;
            r_neg_out <= 1'b0;
            r_err_out <= 1'b1;
          end else begin
            r_bcd_q   <= w_fin_q;
            r_bcd_r   <= w_fin_r;
            r_neg_out <= r_neg;
            r_err_out <= 1'b0;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign bcd_q   = r_bcd_q;
  assign bcd_r   = r_bcd_r;
  assign neg_out = r_neg_out;
  assign err_out = r_err_out;

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd with hand-computed BCD results.
module tb_div_result_bcd;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        negative;
  logic        error;
  logic        busy;
  logic        done;
  logic [11:0] bcd_q;
  logic [11:0] bcd_r;
  logic        neg_out;
  logic        err_out;

  int checks = 0;
  int errors = 0;

  div_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .quotient(quotient), .remainder(remainder),
    .negative(negative), .error(error),
    .busy(busy), .done(done),
    .bcd_q(bcd_q), .bcd_r(bcd_r),
    .neg_out(neg_out), .err_out(err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_BCD_LEADING_BLANK_EN
  localparam logic [11:0] EXP_Q42  = 12'hF42;
  localparam logic [11:0] EXP_R7   = 12'hFF7;
  localparam logic [11:0] EXP_R45  = 12'hF45;
  localparam logic [11:0] EXP_ZERO = 12'hFF0;
`else
  localparam logic [11:0] EXP_Q42  = 12'h042;
  localparam logic [11:0] EXP_R7   = 12'h007;
  localparam logic [11:0] EXP_R45  = 12'h045;
  localparam logic [11:0] EXP_ZERO = 12'h000;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one start; returns edges from the accepting edge until done is seen.
  task automatic convert(input logic [7:0] q, input logic [7:0] r, input logic n,
                         input logic e, output int lat);
    quotient  = q;
    remainder = r;
    negative  = n;
    error     = e;
    start     = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      step();
      lat++;
    end
  endtask

  int lat;
  int pulses;
  int busy_bad;

  initial begin
    reset = 1'b0; start = 1'b0; quotient = '0; remainder = '0;
    negative = 1'b0; error = 1'b0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd_q", bcd_q, 0);
    check("rst_bcd_r", bcd_r, 0);
    check("rst_flags", {neg_out, err_out}, 0);
    reset = 1'b1;
    step();

    // 1: 255 / 0, busy over edges 1..9
    quotient = 8'd255; remainder = 8'd0; negative = 1'b0; error = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    busy_bad = 0;
    lat = 0;
    while (!done && lat < 30) begin
      if (!busy) busy_bad++;
      step();
      lat++;
    end
    check("t1_lat", lat, 9);
    check("t1_busy_during", busy_bad, 0);
    check("t1_busy_after", busy, 0);
    check("t1_bcd_q", bcd_q, 12'h255);
    check("t1_bcd_r", bcd_r, EXP_ZERO);
    check("t1_flags", {neg_out, err_out}, 2'b00);
    step();
    check("t1_done_1cyc", done, 0);

    // 3: error path, negative forced low
    convert(8'd12, 8'd3, 1'b1, 1'b1, lat);
    check("t3_lat", lat, 1);
    check("t3_bcd_q", bcd_q, 12'hFFF);
    check("t3_bcd_r", bcd_r, 12'hFFF);
    check("t3_err", err_out, 1);
    check("t3_neg", neg_out, 0);
    step();
    check("t3_done_1cyc", done, 0);

    // 2: 42 / 7 negative; clears a previous error
    convert(8'd42, 8'd7, 1'b1, 1'b0, lat);
    check("t2_lat", lat, 9);
    check("t2_bcd_q", bcd_q, EXP_Q42);
    check("t2_bcd_r", bcd_r, EXP_R7);
    check("t2_neg", neg_out, 1);
    check("t2_err", err_out, 0);

    // outputs hold while inputs move and no start arrives
    quotient = 8'd1; remainder = 8'd2; negative = 1'b0;
    repeat (4) step();
    check("hold_bcd_q", bcd_q, EXP_Q42);
    check("hold_neg", neg_out, 1);

    // 4: second start at edge 4 with different inputs is ignored
    quotient = 8'd123; remainder = 8'd45; negative = 1'b0; error = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    quotient = 8'd9; remainder = 8'd9; negative = 1'b1; error = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 4;
    while (!done && lat < 30) begin
      step();
      lat++;
    end
    check("t4_lat", lat, 9);
    check("t4_bcd_q", bcd_q, 12'h123);
    check("t4_bcd_r", bcd_r, EXP_R45);
    check("t4_flags", {neg_out, err_out}, 2'b00);
    pulses = 0;
    repeat (15) begin
      step();
      if (done) pulses++;
    end
    check("t4_no_extra_done", pulses, 0);
    error = 1'b0;

    // 5: reset at edge 5 aborts conversion
    quotient = 8'd77; remainder = 8'd66; negative = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    @(posedge clk);
    reset = 1'b0;
    #1;
    check("t5_rst_bcd_q", bcd_q, 0);
    check("t5_rst_bcd_r", bcd_r, 0);
    check("t5_rst_busy", busy, 0);
    pulses = 0;
    repeat (3) begin
      step();
      if (done) pulses++;
    end
    reset = 1'b1;
    repeat (8) begin
      step();
      if (done || busy) pulses++;
    end
    check("t5_no_done", pulses, 0);
    convert(8'd100, 8'd0, 1'b0, 1'b0, lat);
    check("t5_lat", lat, 9);
    check("t5_bcd_q", bcd_q, 12'h100);
    check("t5_bcd_r", bcd_r, EXP_ZERO);

    // 6: back-to-back start in the cycle after done
    convert(8'd199, 8'd88, 1'b0, 1'b0, lat);
    check("t6_lat", lat, 9);
    check("t6_bcd_q", bcd_q, 12'h199);
    check("t6_bcd_r", bcd_r, 12'h088 | (EXP_ZERO & 12'hF00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
